serial_sub: RTL and testbench

- Parametrised bit-serial subtractor: computes diff = a − b − bin over WIDTH clock cycles, one bit per cycle, LSB first.
- One reusable full-subtractor cell plus a registered borrow; the sequential successor to the team's combinational full-subtractor.
- Sits in the arithmetic datapath wherever area matters more than latency; uses a start/busy/done handshake.

---
 rtl/serial_sub_pkg.sv | 9 +
 rtl/serial_sub_if.sv | 32 +++
 rtl/serial_sub_fullsub_cell.sv | 11 +
 rtl/serial_sub.sv | 99 +++++++++
 tb/tb_serial_sub.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and default width.
package serial_sub_pkg;
  localparam int DEF_WIDTH = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/serial_sub_if.sv
// Handshake/operand/result bundle for serial_sub; ovf exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub_if #(
  parameter int WIDTH = serial_sub_pkg::DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, bin,
`ifdef SERIAL_SUB_OVF_EN
    input  ovf,
`endif
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
`ifdef SERIAL_SUB_OVF_EN
    output ovf,
`endif
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_sub_fullsub_cell.sv
// One-bit combinational full subtractor: d = x - y - bi (mod 2), bo = borrow out.
module fullsub_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~x & bi) | (y & bi);
endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor, LSB first, one bit per clock, start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic        i_clk,
  input  logic        i_rst,
  serial_sub_if.slave bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res_sr;
  logic             r_brw;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             r_ovf;
`endif

  logic w_d;
  logic w_bo;

  fullsub_cell u_cell (
    .x  (r_a_sr[0]),
    .y  (r_b_sr[0]),
    .bi (r_brw),
    .d  (w_d),
    .bo (w_bo)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_brw    <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_a_sr  <= bus.a;
            r_b_sr  <= bus.b;
            r_brw   <= bus.bin;
            r_cnt   <= '0;
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          r_res_sr <= {w_d, r_res_sr[WIDTH-1:1]};
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_brw    <= w_bo;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            // Final step: publish result including this cycle's bit.
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_cnt   <= '0;
            r_diff  <= {w_d, r_res_sr[WIDTH-1:1]};
            r_bout  <= w_bo;
`ifdef SERIAL_SUB_OVF_EN
            r_ovf   <= r_brw ^ w_bo;
`endif
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf  = r_ovf;
`endif
endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed plan plus randomized operations vs. an integer model.
module tb_serial_sub;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_sub_if #(.WIDTH(W)) bus ();

  serial_sub #(.WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  logic cx, cy, cbi, cd, cbo;
  fullsub_cell u_cell_chk (.x(cx), .y(cy), .bi(cbi), .d(cd), .bo(cbo));

  int n_chk = 0;
  int n_err = 0;
  logic [W-1:0] last_diff = '0;
  logic         last_bout = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer subtraction.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int r;
    logic [W-1:0] d;
    r = int'(a) - int'(b) - int'(bin);
    d = W'(r);
    return {(r < 0), d};
  endfunction

  function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int r;
    r = int'($signed(a)) - int'($signed(b)) - int'(bin);
    return (r < -(2 ** (W - 1))) || (r > (2 ** (W - 1)) - 1);
  endfunction

  logic [W-1:0] cur_a, cur_b;
  logic         cur_bin;

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    bus.start = 1'b1;
    bus.a = a; bus.b = b; bus.bin = bin;
    cur_a = a; cur_b = b; cur_bin = bin;
    tick();
    bus.start = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.bin = 1'($urandom);
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    chk("done_after_start", 32'(bus.done), 32'd0);
  endtask

  task automatic wait_done(input int exp_lat);
    int cyc;
    logic [W:0] e;
    cyc = 0;
    while (!bus.done && cyc < 4 * W) begin
      chk("busy_in_run", 32'(bus.busy), 32'd1);
      chk("diff_held", 32'(bus.diff), 32'(last_diff));
      tick();
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(exp_lat));
    e = model(cur_a, cur_b, cur_bin);
    chk("diff", 32'(bus.diff), 32'(e[W-1:0]));
    chk("bout", 32'(bus.bout), 32'(e[W]));
    chk("busy_at_done", 32'(bus.busy), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf", 32'(bus.ovf), 32'(model_ovf(cur_a, cur_b, cur_bin)));
`endif
    last_diff = e[W-1:0];
    last_bout = e[W];
  endtask

  initial begin
    int pulses;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;

    // Exhaustive cell check against arithmetic.
    for (int v = 0; v < 8; v++) begin
      int r;
      cx = v[2]; cy = v[1]; cbi = v[0];
      #1;
      r = int'(cx) - int'(cy) - int'(cbi);
      chk("cell_d", 32'(cd), 32'(r & 1));
      chk("cell_bo", 32'(cbo), 32'(r < 0));
    end

    tick(); tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_bout", 32'(bus.bout), 32'd0);
    rst = 1'b0;
    tick();

    start_op(8'h5A, 8'h3C, 1'b0);
    wait_done(W);
    chk("dir_5a_3c", 32'(bus.diff), 32'h1E);
    tick();
    chk("done_pulse_len", 32'(bus.done), 32'd0);

    start_op(8'h00, 8'h01, 1'b0);
    wait_done(W);
    chk("dir_0_1_bout", 32'(bus.bout), 32'd1);
    start_op(8'hFF, 8'hFF, 1'b1);   // back-to-back in done cycle
    wait_done(W);
    chk("dir_ff_ff_1", 32'(bus.diff), 32'hFF);

    // Start re-asserted mid-RUN must be ignored.
    tick();
    start_op(8'h9C, 8'h27, 1'b1);
    bus.start = 1'b1; bus.a = 8'h11;
    tick();
    bus.start = 1'b0;
    tick();
    wait_done(W - 2);
    pulses = 0;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      if (bus.done) pulses++;
    end
    chk("midrun_extra_done", 32'(pulses), 32'd0);

    // Reset in the 4th RUN cycle abandons the op.
    start_op(8'h44, 8'h12, 1'b0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_done", 32'(bus.done), 32'd0);
    chk("mrst_diff", 32'(bus.diff), 32'd0);
    chk("mrst_bout", 32'(bus.bout), 32'd0);
    last_diff = '0; last_bout = 1'b0;
    pulses = 0;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      if (bus.done) pulses++;
    end
    chk("mrst_no_done", 32'(pulses), 32'd0);

`ifdef SERIAL_SUB_OVF_EN
    start_op(8'h80, 8'h01, 1'b0);
    wait_done(W);
    chk("ovf_80_01", 32'(bus.ovf), 32'd1);
    start_op(8'h05, 8'h03, 1'b0);
    wait_done(W);
    chk("ovf_05_03", 32'(bus.ovf), 32'd0);
`endif

    // Randomized ops with random idle gaps or back-to-back starts.
    for (int n = 0; n < 40; n++) begin
      start_op(W'($urandom), W'($urandom), 1'($urandom));
      wait_done(W);
      if ($urandom_range(0, 1) == 1) begin
        int gap;
        gap = $urandom_range(1, 3);
        for (int g = 0; g < gap; g++) begin
          tick();
          chk("idle_busy", 32'(bus.busy), 32'd0);
          chk("idle_diff", 32'(bus.diff), 32'(last_diff));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
